// File: rtl/aes_inv_core.sv
// rtl/aes_inv_core.sv - iterative AES-128 inverse cipher, one round per clock
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      single-cycle request, sampled only while idle
//   key        128-bit cipher key, byte 0 in [127:120]
//   ciphertext 128-bit input block, byte 0 in [127:120]
//   plaintext  registered result, held until the next completed block
//   done       one-cycle pulse, plaintext valid
//   busy       high while a block is being processed
module aes_inv_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  // Byte x of each table sits at bits [8x +: 8] of an ascending vector,
  // so the literal reads in the usual row-major FIPS-197 order.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_t;

  // Block viewed as 16 bytes, element 0 = most significant byte.
  typedef logic [0:15][7:0] blk_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk [0:10];
  logic [127:0] ct_q;
  logic [127:0] st_q;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k in GF(2^8): sum of b, 2b, 4b, 8b per bit of k.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic blk_t inv_shift_rows(input blk_t s);
    return {s[0],  s[13], s[10], s[7],
            s[4],  s[1],  s[14], s[11],
            s[8],  s[5],  s[2],  s[15],
            s[12], s[9],  s[6],  s[3]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Key schedule step: rk[cnt] from rk[cnt-1].
  logic [127:0] prev_rk;
  logic [31:0]  rot_w, sub_w, tmp_w;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] key_next;

  assign prev_rk  = rk[cnt_q - 4'd1];
  assign rot_w    = {prev_rk[23:0], prev_rk[31:24]};
  assign sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                     sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
  assign tmp_w    = sub_w ^ {rcon(cnt_q), 24'h000000};
  assign nw0      = prev_rk[127:96] ^ tmp_w;
  assign nw1      = prev_rk[95:64]  ^ nw0;
  assign nw2      = prev_rk[63:32]  ^ nw1;
  assign nw3      = prev_rk[31:0]   ^ nw2;
  assign key_next = {nw0, nw1, nw2, nw3};

  // Round datapath shared by ROUND and FINAL.
  blk_t             shifted, isb;
  logic [127:0]     ark;
  logic [0:3][31:0] ark_c, mix_c;
  logic [127:0]     round_out, final_out;

  assign shifted = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    assign isb[i] = inv_sbox(shifted[i]);
  end

  assign ark   = isb ^ rk[cnt_q];
  assign ark_c = ark;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix_c[c] = inv_mix_col(ark_c[c]);
  end

  assign round_out = mix_c;
  assign final_out = isb ^ rk[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      cnt_q <= 4'd0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = KEXP;
          cnt_d = 4'd1;
        end
      end
      KEXP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) fsm_d = INIT;
      end
      INIT: begin
        cnt_d = 4'd9;
        fsm_d = ROUND;
      end
      ROUND: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: fsm_d = IDLE;
      default: begin
        fsm_d = IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  assign busy = (fsm_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plaintext <= 128'd0;
      done      <= 1'b0;
    end else begin
      done <= (fsm_q == FINAL);
      if (fsm_q == FINAL) plaintext <= final_out;
    end
  end

  // Key/state storage carries no reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    case (fsm_q)
      IDLE: begin
        if (start) begin
          rk[0] <= key;
          ct_q  <= ciphertext;
        end
      end
      KEXP:    rk[cnt_q] <= key_next;
      INIT:    st_q <= ct_q ^ rk[10];
      ROUND:   st_q <= round_out;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_core.sv
// tb/tb_aes_inv_core.sv - scoreboard bench for aes_inv_core
module tb_aes_inv_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_inv_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: forward AES-128 built from GF(2^8) arithmetic.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, a;
    for (int x = 0; x < 256; x++) begin
      a = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = p[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rd + b/4][31 - 8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) out[127 - 8*b -: 8] = s[b];
    return out;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got plaintext %h expected no done", plaintext);
      end else begin
        check("plaintext", plaintext, exp_q.pop_front());
      end
    end
  end

  // Called on a negedge; returns one negedge later with start released.
  task automatic pulse_start(input logic [127:0] k, input logic [127:0] c,
                             input bit push, input logic [127:0] exp);
    start = 1'b1;
    key = k;
    ciphertext = c;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected 21", lat);
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] k,
                           input logic [127:0] c, input logic [127:0] p);
    int lat;
    pulse_start(k, c, 1'b1, p);
    check({name, "_busy_after_start"}, busy, 1);
    wait_done(0, lat);
    check({name, "_latency"}, lat, 21);
    check({name, "_busy_in_done"}, busy, 0);
    @(negedge clk);
    check({name, "_done_width"}, done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, lat2, d0;
    logic [127:0] rk_r, rp, rc;
    build_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    ciphertext = '0;
    repeat (3) @(negedge clk);
    check("reset_plaintext", plaintext, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_block("c1", C1K, C1C, C1P);
    run_block("appb", BK, BC, BP);
    run_block("zero", 128'd0, ZC, 128'd0);

    // start pulse and input changes while busy must not disturb the block
    d0 = done_cnt;
    pulse_start(C1K, C1C, 1'b1, C1P);
    repeat (3) @(negedge clk);
    key = {$urandom, $urandom, $urandom, $urandom};
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    check("busy_test_latency", lat, 21);
    repeat (25) @(negedge clk);
    check("busy_test_done_count", done_cnt - d0, 1);

    // reset in the middle of a block
    pulse_start(C1K, C1C, 1'b0, '0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_plaintext", plaintext, 0);
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_plaintext_held", plaintext, 0);
    run_block("c1_after_abort", C1K, C1C, C1P);

    // back-to-back: second start issued in the first done cycle
    pulse_start(C1K, C1C, 1'b1, C1P);
    wait_done(0, lat);
    check("b2b_first_latency", lat, 21);
    pulse_start(BK, BC, 1'b1, BP);
    wait_done(0, lat2);
    check("b2b_spacing", lat2 + 1, 22);
    @(negedge clk);

    // loopback: model encrypts random blocks, core must recover the plaintext
    for (int n = 0; n < 8; n++) begin
      rk_r = {$urandom, $urandom, $urandom, $urandom};
      rp   = {$urandom, $urandom, $urandom, $urandom};
      rc   = model_enc(rk_r, rp);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start(rk_r, rc, 1'b1, rp);
      wait_done(0, lat);
      check("loopback_latency", lat, 21);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_core.md
# aes_inv_core

Iterative AES-128 decryption core, one round per clock: the receive-side counterpart of the encryption core `aes_core` in the serial security wrapper. It accepts a 128-bit key and ciphertext on a start pulse and returns the FIPS-197 inverse-cipher plaintext with a one-cycle done pulse. Round keys are expanded on-chip before decryption begins, so the block accepts the same key word as the encryption core.

## Interface
Parameters:
- none. AES-128 only: Nk=4, Nr=10.

Ports:
- clk  input  1  clock; all logic on its rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- key  input  128  cipher key, byte 0 in bits [127:120]
- ciphertext  input  128  input block, byte 0 in bits [127:120]
- plaintext  output  128  registered result
- done  output  1  one-cycle pulse; plaintext valid
- busy  output  1  high from the cycle after start is accepted until done is asserted

## Operation
- Byte/column order follows FIPS-197: state column c = bytes 4c..4c+3, MSB-first in the 128-bit word.
- Capture: in IDLE with start=1, key and ciphertext are registered. Later changes on those inputs have no effect until the next accepted start.
- FSM states: IDLE, KEXP, INIT, ROUND, FINAL.
  - IDLE: start=1 -> KEXP, with rk[0]=key and round counter=1.
  - KEXP: one cycle per round key. rk[i]=f(rk[i-1]) using RotWord, SubWord (forward S-box) and Rcon[i]. Rcon = 01,02,04,08,10,20,40,80,1b,36. After i=10 -> INIT.
  - INIT: state = ct XOR rk[10]; counter=9 -> ROUND.
  - ROUND: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[counter]). Counter decrements. After the counter=1 cycle -> FINAL.
  - FINAL: plaintext = InvSubBytes(InvShiftRows(state)) XOR rk[0]; done=1 -> IDLE.
- The eleven round keys are stored in registers: an 11 x 128 array, or an equivalent scheme that yields rk[10]..rk[0] in reverse order.
- The S-box and inverse S-box may be lookup functions or GF(2^8) inversion plus affine transform. Both must be exact FIPS-197 tables.
- InvMixColumns uses matrix {0e,0b,0d,09} with GF(2^8) reduction polynomial 0x11b.
- start while busy=1 is ignored. It is neither queued nor aborts the operation.

## Timing
- Reset (rst_n=0 at a rising edge): FSM -> IDLE, plaintext=0, done=0, busy=0, counter=0. Round-key and state registers need no reset value.
- Reset mid-operation aborts immediately. No done pulse is produced for the aborted block, and plaintext reads 0.
- Latency: start sampled at edge E0.
  - KEXP occupies E1..E10.
  - INIT is E11.
  - ROUND is E12..E20.
  - FINAL is E21.
  - done and the new plaintext are visible after E21, i.e. 21 cycles after the start edge.
- busy=1 after E0 through E21. done=1 for exactly the cycle after E21. busy=0 in that same cycle, so start may be asserted in the done cycle.
- Back-to-back: a start accepted in the done cycle begins a new block. Throughput is 1 block per 22 cycles.
- plaintext holds its value until the FINAL of the next completed block or until reset.

## Test plan
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff, done exactly 21 cycles after start, single-cycle pulse.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32 -> plaintext=3243f6a8885a308d313198a2e0370734.
- Zero key: key=0, ct=66e94bd4ef8a2c3b884cfa59ca342b2e -> plaintext=0. Also covers Rcon and the key schedule with all-zero input.
- Busy behaviour: pulse start again at cycle 5, and change key/ciphertext at cycle 3 -> C.1 result unchanged, exactly one done pulse.
- Reset mid-operation: assert rst_n=0 at cycle 12 -> done never pulses, plaintext=0, busy=0. A fresh start then gives the correct C.1 result.
- Back-to-back: start App. B in the C.1 done cycle -> second done 22 cycles after the first, plaintext=3243f6a8885a308d313198a2e0370734. Loopback through `aes_core` with random key/plaintext -> original plaintext recovered.
